// File: rtl/memory_access_pkg.sv
// Shared types for the memory stage.
//   common : data-bus width, access size encoding, dbus request/response
//            payloads and an alignment helper.
//   pipes  : stage control fields and the execute/memory stage bundles.
package common;
    localparam int unsigned XLEN   = 64;
    localparam int unsigned STRB_W = XLEN / 8;

    typedef logic [XLEN-1:0] word_t;

    // Access size: 1, 2, 4 or 8 bytes
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic              valid;
        word_t             addr;
        msize_t            size;
        logic [STRB_W-1:0] strobe;
        word_t             data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    // True when the low address bits are not a multiple of the access size
    function automatic logic misaligned(word_t addr, msize_t size);
        logic [2:0] mask;
        mask = 3'((4'd1 << size) - 4'd1);
        return (addr[2:0] & mask) != 3'd0;
    endfunction
endpackage

package pipes;
    import common::*;

    typedef struct packed {
        logic   MemRead;
        logic   MemWrite;
        msize_t MemSize;
        logic   MemUnsigned;
    } control_t;

    typedef struct packed {
        logic     valid;
        word_t    pc;
        control_t ctl;
        word_t    alu;
        word_t    rs2;
    } execute_data_t;

    typedef struct packed {
        logic     valid;
        word_t    pc;
        control_t ctl;
        word_t    alu;
        word_t    rdata;
        logic     exc_misalign;
    } memory_data_t;
endpackage

// File: rtl/memory_access_if.sv
// Data-bus bundle between the memory stage (master) and memory (slave).
//   dreq  : request payload, driven by the master
//   dresp : response payload, driven by the slave
interface memory_access_if;
    import common::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/memory_access_mem_format.sv
// Combinational data formatting for the memory stage.
//   size, off     : access size and byte offset within the 8-byte word
//   store_data    : register value to store
//   load_raw      : raw 64-bit word returned by the bus
//   load_unsigned : zero-extend instead of sign-extend loaded data
//   strobe_c      : byte enables for a store
//   wdata_c       : store data aligned to its byte lane
//   rdata_c       : load data shifted down, truncated and extended
module mem_format
    import common::*;
(
    input  msize_t            size,
    input  logic [2:0]        off,
    input  word_t             store_data,
    input  word_t             load_raw,
    input  logic              load_unsigned,
    output logic [STRB_W-1:0] strobe_c,
    output word_t             wdata_c,
    output word_t             rdata_c
);
    logic [5:0] shamt;
    word_t      loaded;

    assign shamt   = {off, 3'b000};
    assign wdata_c = store_data << shamt;
    assign loaded  = load_raw >> shamt;

    // Per-size byte enables and load truncation/extension
    always_comb begin
        strobe_c = '0;
        rdata_c  = '0;
        case (size)
            MSIZE1: begin
                strobe_c = 8'h01 << off;
                rdata_c  = load_unsigned ? XLEN'(loaded[7:0])
                                         : {{56{loaded[7]}}, loaded[7:0]};
            end
            MSIZE2: begin
                strobe_c = 8'h03 << off;
                rdata_c  = load_unsigned ? XLEN'(loaded[15:0])
                                         : {{48{loaded[15]}}, loaded[15:0]};
            end
            MSIZE4: begin
                strobe_c = 8'h0F << off;
                rdata_c  = load_unsigned ? XLEN'(loaded[31:0])
                                         : {{32{loaded[31]}}, loaded[31:0]};
            end
            default: begin
                strobe_c = 8'hFF << off;
                rdata_c  = loaded;
            end
        endcase
    end
endmodule

// File: rtl/memory_access.sv
// Pipeline memory stage: passes non-memory instructions through in one cycle
// and runs a data-bus request/response for loads and stores, stalling the
// front of the pipeline until data_ok.
//   clk    : clock, all state on rising edge
//   reset  : synchronous, active-low
//   dataE  : execute-stage bundle, held by upstream while stallM=1
//   dbus   : data bus (dreq registered out, dresp in)
//   dataM  : registered result bundle for writeback
//   stallM : combinational stall request to upstream
// Optional feature: define MEM_MISALIGN_CHECK_EN to trap misaligned accesses
// in place of issuing them on the bus.
module memory_access
    import common::*;
    import pipes::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  execute_data_t          dataE,
    memory_access_if.master        dbus,
    output memory_data_t           dataM,
    output logic                   stallM
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    word_t             lat_pc;
    word_t             lat_alu;
    control_t          lat_ctl;
    logic              mem_op;
    logic              misalign;
    msize_t            fmt_size;
    logic [2:0]        fmt_off;
    logic [STRB_W-1:0] fmt_strobe;
    word_t             fmt_wdata;
    word_t             fmt_rdata;
    logic              unused_addr_ok;

    // Completion is data_ok only
    assign unused_addr_ok = dbus.dresp.addr_ok;

    assign mem_op = dataE.valid && (dataE.ctl.MemRead || dataE.ctl.MemWrite);

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = misaligned(dataE.alu, dataE.ctl.MemSize);
`else
    assign misalign = 1'b0;
`endif

    // Store path formats the incoming op in IDLE; load path formats the latched op in BUSY
    assign fmt_size = (state == BUSY) ? lat_ctl.MemSize : dataE.ctl.MemSize;
    assign fmt_off  = (state == BUSY) ? lat_alu[2:0]    : dataE.alu[2:0];

    mem_format u_fmt (
        .size          (fmt_size),
        .off           (fmt_off),
        .store_data    (dataE.rs2),
        .load_raw      (dbus.dresp.data),
        .load_unsigned (lat_ctl.MemUnsigned),
        .strobe_c      (fmt_strobe),
        .wdata_c       (fmt_wdata),
        .rdata_c       (fmt_rdata)
    );

    // Stall while an op is being accepted or its response is outstanding
    always_comb begin
        stallM = 1'b0;
        case (state)
            IDLE:    stallM = mem_op && !misalign;
            BUSY:    stallM = !dbus.dresp.data_ok;
            default: stallM = 1'b0;
        endcase
    end

    // Stage FSM with registered bus request and result bundle
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            dbus.dreq <= '0;
            dataM     <= '0;
            lat_pc    <= '0;
            lat_alu   <= '0;
            lat_ctl   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && misalign) begin
                        dataM.valid        <= 1'b1;
                        dataM.pc           <= dataE.pc;
                        dataM.ctl          <= dataE.ctl;
                        dataM.alu          <= dataE.alu;
                        dataM.rdata        <= '0;
                        dataM.exc_misalign <= 1'b1;
                    end else if (mem_op) begin
                        dbus.dreq.valid  <= 1'b1;
                        dbus.dreq.addr   <= dataE.alu;
                        dbus.dreq.size   <= dataE.ctl.MemSize;
                        dbus.dreq.strobe <= dataE.ctl.MemWrite ? fmt_strobe : '0;
                        dbus.dreq.data   <= dataE.ctl.MemWrite ? fmt_wdata : '0;
                        lat_pc           <= dataE.pc;
                        lat_alu          <= dataE.alu;
                        lat_ctl          <= dataE.ctl;
                        dataM            <= '0;
                        state            <= BUSY;
                    end else begin
                        dataM.valid        <= dataE.valid;
                        dataM.pc           <= dataE.pc;
                        dataM.ctl          <= dataE.ctl;
                        dataM.alu          <= dataE.alu;
                        dataM.rdata        <= '0;
                        dataM.exc_misalign <= 1'b0;
                    end
                end
                BUSY: begin
                    if (dbus.dresp.data_ok) begin
                        dataM.valid        <= 1'b1;
                        dataM.pc           <= lat_pc;
                        dataM.ctl          <= lat_ctl;
                        dataM.alu          <= lat_alu;
                        dataM.rdata        <= lat_ctl.MemWrite ? '0 : fmt_rdata;
                        dataM.exc_misalign <= 1'b0;
                        dbus.dreq          <= '0;
                        state              <= IDLE;
                    end else begin
                        dataM.valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios plus randomized
// operations compared against a byte-lane reference model.
module tb_memory_access;
    import common::*;
    import pipes::*;

    logic          clk;
    logic          reset;
    execute_data_t dataE;
    memory_data_t  dataM;
    logic          stallM;

    int n_checks = 0;
    int n_fail   = 0;

    memory_access_if bus ();

    memory_access dut (
        .clk    (clk),
        .reset  (reset),
        .dataE  (dataE),
        .dbus   (bus),
        .dataM  (dataM),
        .stallM (stallM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int nbytes(msize_t s);
        return 1 << int'(s);
    endfunction

    function automatic logic [7:0] m_strobe(msize_t s, word_t a);
        logic [15:0] full;
        full = 16'(((1 << nbytes(s)) - 1) << a[2:0]);
        return full[7:0];
    endfunction

    function automatic word_t m_wdata(word_t rs2, word_t a);
        return rs2 << (8 * int'(a[2:0]));
    endfunction

    function automatic word_t m_rdata(word_t raw, msize_t s, word_t a, logic uns);
        word_t sh, mask, v;
        int    nb;
        sh = raw >> (8 * int'(a[2:0]));
        nb = nbytes(s) * 8;
        if (nb == 64) return sh;
        mask = (64'd1 << nb) - 64'd1;
        v    = sh & mask;
        if (!uns && v[nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic control_t mk_ctl(logic rd, logic wr, msize_t s, logic uns);
        control_t c;
        c.MemRead     = rd;
        c.MemWrite    = wr;
        c.MemSize     = s;
        c.MemUnsigned = uns;
        return c;
    endfunction

    // Presents one op, acts as a bus responder answering after `delay` BUSY
    // cycles, and reports what was observed. Bounded to 60 cycles.
    task automatic do_mem_op(input control_t ctl, input word_t pc, input word_t addr,
                             input word_t rs2, input word_t raw, input int delay,
                             output int stalls, output int reqs, output bit stable,
                             output bit idle_before, output dbus_req_t req,
                             output memory_data_t res, output int latency, output int req_at);
        int busy;
        bit prev;
        idle_before = !bus.dreq.valid;
        stalls = 0; reqs = 0; stable = 1'b1; req = '0; res = '0;
        latency = -1; req_at = -1; busy = 0; prev = 1'b0;
        dataE.valid = 1'b1;
        dataE.pc    = pc;
        dataE.ctl   = ctl;
        dataE.alu   = addr;
        dataE.rs2   = rs2;
        bus.dresp.addr_ok = 1'($urandom);
        bus.dresp.data_ok = 1'b0;
        bus.dresp.data    = {$urandom, $urandom};
        #1;
        if (stallM) stalls++;
        for (int cyc = 1; cyc <= 60 && latency < 0; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.dreq.valid) begin
                if (!prev) begin
                    reqs++;
                    if (reqs == 1) begin
                        req    = bus.dreq;
                        req_at = cyc;
                    end
                end else if (bus.dreq !== req) begin
                    stable = 1'b0;
                end
            end
            prev = bus.dreq.valid;
            if (dataM.valid) begin
                latency = cyc;
                res     = dataM;
                dataE   = '0;
                bus.dresp = '0;
            end else begin
                if (bus.dreq.valid) begin
                    bus.dresp.addr_ok = 1'($urandom);
                    bus.dresp.data_ok = (busy == delay);
                    bus.dresp.data    = (busy == delay) ? raw : {$urandom, $urandom};
                    busy++;
                end else begin
                    bus.dresp = '0;
                end
                #1;
                if (stallM) stalls++;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        dataE = '0;
        bus.dresp = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.dreq !== '0) begin n_fail++; $display("FAIL reset_dreq: got %h expected 0", bus.dreq); end
        n_checks++;
        if (dataM !== '0) begin n_fail++; $display("FAIL reset_dataM: got %h expected 0", dataM); end
        n_checks++;
        if (stallM !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stallM); end
        reset = 1'b1;
    endtask

    task automatic test_alu();
        int st, rq, lat, ra; bit sb, ib; dbus_req_t r; memory_data_t m;
        do_mem_op(mk_ctl(0, 0, MSIZE8, 0), 64'h400, 64'h1234, 64'h55, 64'h0, 0,
                  st, rq, sb, ib, r, m, lat, ra);
        n_checks++;
        if (st !== 0) begin n_fail++; $display("FAIL alu_stall: got %0d expected 0", st); end
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL alu_latency: got %0d expected 1", lat); end
        n_checks++;
        if (m.alu !== 64'h1234) begin n_fail++; $display("FAIL alu_value: got %h expected 1234", m.alu); end
        n_checks++;
        if (rq !== 0 || bus.dreq.valid !== 1'b0) begin
            n_fail++; $display("FAIL alu_noreq: got %0d reqs valid=%b expected 0", rq, bus.dreq.valid);
        end
    endtask

    task automatic test_sb();
        int st, rq, lat, ra; bit sb, ib; dbus_req_t r; memory_data_t m;
        do_mem_op(mk_ctl(0, 1, MSIZE1, 0), 64'h500, 64'h1003, 64'hAB, 64'h0, 0,
                  st, rq, sb, ib, r, m, lat, ra);
        n_checks++;
        if (ra !== 1) begin n_fail++; $display("FAIL sb_req_at: got %0d expected 1", ra); end
        n_checks++;
        if (r.strobe !== 8'h08) begin n_fail++; $display("FAIL sb_strobe: got %h expected 08", r.strobe); end
        n_checks++;
        if (r.data !== 64'hAB00_0000) begin n_fail++; $display("FAIL sb_data: got %h expected ab000000", r.data); end
        n_checks++;
        if (r.addr !== 64'h1003 || r.size !== MSIZE1) begin
            n_fail++; $display("FAIL sb_addr: got %h/%0d expected 1003/0", r.addr, r.size);
        end
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL sb_latency: got %0d expected 2", lat); end
        n_checks++;
        if (m.rdata !== 64'h0 || m.pc !== 64'h500) begin
            n_fail++; $display("FAIL sb_result: got rdata %h pc %h expected 0/500", m.rdata, m.pc);
        end
    endtask

    task automatic test_lh();
        int st, rq, lat, ra; bit sb, ib; dbus_req_t r; memory_data_t m;
        for (int u = 0; u < 2; u++) begin
            do_mem_op(mk_ctl(1, 0, MSIZE2, 1'(u)), 64'h600, 64'h2006, 64'h0,
                      64'h8001_0000_0000_0000, 3, st, rq, sb, ib, r, m, lat, ra);
            n_checks++;
            if (st !== 4) begin n_fail++; $display("FAIL lh_stall_cycles u=%0d: got %0d expected 4", u, st); end
            n_checks++;
            if (lat !== 5) begin n_fail++; $display("FAIL lh_latency u=%0d: got %0d expected 5", u, lat); end
            n_checks++;
            if (m.rdata !== (u == 0 ? 64'hFFFF_FFFF_FFFF_8001 : 64'h8001)) begin
                n_fail++; $display("FAIL lh_rdata u=%0d: got %h", u, m.rdata);
            end
            n_checks++;
            if (r.strobe !== 8'h00 || !sb || rq !== 1) begin
                n_fail++; $display("FAIL lh_req u=%0d: strobe %h stable %b reqs %0d expected 00/1/1", u, r.strobe, sb, rq);
            end
        end
    endtask

    task automatic test_back_to_back();
        int st, rq, lat, ra; bit sb, ib; dbus_req_t r; memory_data_t m;
        word_t raw, rs2;
        raw = {$urandom, $urandom};
        rs2 = {$urandom, $urandom};
        do_mem_op(mk_ctl(1, 0, MSIZE8, 0), 64'h700, 64'h10, 64'h0, raw,
                  int'($urandom_range(0, 3)), st, rq, sb, ib, r, m, lat, ra);
        n_checks++;
        if (rq !== 1 || !sb) begin n_fail++; $display("FAIL b2b_ld_req: reqs %0d stable %b expected 1/1", rq, sb); end
        n_checks++;
        if (m.rdata !== raw) begin n_fail++; $display("FAIL b2b_ld_rdata: got %h expected %h", m.rdata, raw); end
        do_mem_op(mk_ctl(0, 1, MSIZE8, 0), 64'h704, 64'h18, rs2, 64'h0,
                  int'($urandom_range(0, 3)), st, rq, sb, ib, r, m, lat, ra);
        n_checks++;
        if (rq !== 1 || !sb) begin n_fail++; $display("FAIL b2b_sd_req: reqs %0d stable %b expected 1/1", rq, sb); end
        n_checks++;
        if (!ib || ra !== 1) begin n_fail++; $display("FAIL b2b_gap: idle %b req_at %0d expected 1/1", ib, ra); end
        n_checks++;
        if (r.data !== rs2 || r.strobe !== 8'hFF || r.addr !== 64'h18) begin
            n_fail++; $display("FAIL b2b_sd_fields: data %h strobe %h addr %h", r.data, r.strobe, r.addr);
        end
    endtask

    task automatic test_reset_busy();
        int st, rq, lat, ra; bit sb, ib; dbus_req_t r; memory_data_t m;
        bit seen;
        dataE.valid = 1'b1;
        dataE.pc    = 64'h800;
        dataE.ctl   = mk_ctl(1, 0, MSIZE4, 0);
        dataE.alu   = 64'h100;
        dataE.rs2   = 64'h0;
        bus.dresp   = '0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.dreq.valid !== 1'b1) begin n_fail++; $display("FAIL rstbusy_req: got %b expected 1", bus.dreq.valid); end
        reset = 1'b0;
        dataE = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        n_checks++;
        if (bus.dreq !== '0 || dataM !== '0) begin
            n_fail++; $display("FAIL rstbusy_clear: dreq %h dataM %h expected 0", bus.dreq, dataM);
        end
        @(posedge clk);
        #1;
        bus.dresp.data_ok = 1'b1;
        bus.dresp.data    = 64'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.dresp = '0;
        seen = 1'b0;
        repeat (3) begin
            if (dataM.valid || bus.dreq.valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL rstbusy_ghost: got output after stray data_ok expected none"); end
        do_mem_op(mk_ctl(0, 0, MSIZE8, 0), 64'h900, 64'h77, 64'h0, 64'h0, 0,
                  st, rq, sb, ib, r, m, lat, ra);
        n_checks++;
        if (lat !== 1 || m.alu !== 64'h77) begin
            n_fail++; $display("FAIL rstbusy_idle: latency %0d alu %h expected 1/77", lat, m.alu);
        end
    endtask

    task automatic test_misalign();
        int st, rq, lat, ra; bit sb, ib; dbus_req_t r; memory_data_t m;
        word_t raw;
        raw = {$urandom, $urandom};
        do_mem_op(mk_ctl(1, 0, MSIZE4, 0), 64'hA00, 64'h2, 64'h0, raw, 0,
                  st, rq, sb, ib, r, m, lat, ra);
`ifdef MEM_MISALIGN_CHECK_EN
        n_checks++;
        if (rq !== 0 || st !== 0) begin n_fail++; $display("FAIL misalign_noreq: reqs %0d stalls %0d expected 0/0", rq, st); end
        n_checks++;
        if (lat !== 1 || m.exc_misalign !== 1'b1 || m.rdata !== 64'h0) begin
            n_fail++; $display("FAIL misalign_exc: latency %0d exc %b rdata %h expected 1/1/0", lat, m.exc_misalign, m.rdata);
        end
`else
        n_checks++;
        if (rq !== 1 || r.addr !== 64'h2) begin n_fail++; $display("FAIL misalign_issue: reqs %0d addr %h expected 1/2", rq, r.addr); end
        n_checks++;
        if (m.exc_misalign !== 1'b0 || m.rdata !== m_rdata(raw, MSIZE4, 64'h2, 1'b0)) begin
            n_fail++; $display("FAIL misalign_load: exc %b rdata %h expected 0/%h", m.exc_misalign, m.rdata, m_rdata(raw, MSIZE4, 64'h2, 1'b0));
        end
`endif
    endtask

    task automatic test_random();
        int st, rq, lat, ra; bit sb, ib; dbus_req_t r; memory_data_t m;
        for (int i = 0; i < 24; i++) begin
            int kind, dly;
            msize_t sz;
            logic uns;
            word_t addr, rs2, raw, pc, exp_rd;
            int exp_lat, exp_st, exp_rq;
            kind = int'($urandom_range(0, 2));
            sz   = msize_t'($urandom_range(0, 3));
            uns  = 1'($urandom);
            dly  = int'($urandom_range(0, 3));
            addr = 64'($urandom_range(0, 16'hFFFF));
`ifdef MEM_MISALIGN_CHECK_EN
            addr = addr & ~64'(nbytes(sz) - 1);
`endif
            rs2  = {$urandom, $urandom};
            raw  = {$urandom, $urandom};
            pc   = 64'($urandom);
            do_mem_op(mk_ctl(kind == 1, kind == 2, sz, uns), pc, addr, rs2, raw, dly,
                      st, rq, sb, ib, r, m, lat, ra);
            exp_lat = (kind == 0) ? 1 : dly + 2;
            exp_st  = (kind == 0) ? 0 : dly + 1;
            exp_rq  = (kind == 0) ? 0 : 1;
            exp_rd  = (kind == 1) ? m_rdata(raw, sz, addr, uns) : 64'h0;
            n_checks++;
            if (lat !== exp_lat || st !== exp_st || rq !== exp_rq || !sb) begin
                n_fail++;
                $display("FAIL rand%0d_timing: lat %0d stall %0d reqs %0d stable %b expected %0d/%0d/%0d/1",
                         i, lat, st, rq, sb, exp_lat, exp_st, exp_rq);
            end
            n_checks++;
            if (m.pc !== pc || m.alu !== addr || m.rdata !== exp_rd || m.exc_misalign !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_result: pc %h alu %h rdata %h expected %h/%h/%h", i, m.pc, m.alu, m.rdata, pc, addr, exp_rd);
            end
            if (kind != 0) begin
                n_checks++;
                if (r.addr !== addr || r.size !== sz ||
                    r.strobe !== ((kind == 2) ? m_strobe(sz, addr) : 8'h00) ||
                    (kind == 2 && r.data !== m_wdata(rs2, addr))) begin
                    n_fail++;
                    $display("FAIL rand%0d_req: addr %h size %0d strobe %h data %h", i, r.addr, r.size, r.strobe, r.data);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        dataE = '0;
        bus.dresp = '0;
        test_reset();
        @(posedge clk);
        #1;
        test_alu();
        test_sb();
        test_lh();
        test_back_to_back();
        test_reset_busy();
        test_misalign();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_access.md
# memory_access

Pipeline memory stage: consumes the registered execute-stage bundle (`execute_data_t`), performs loads and stores over the data bus (`dbus_req_t` / `dbus_resp_t`) and registers the result into `memory_data_t` for writeback. Non-memory instructions pass through in one cycle. Memory instructions run a request/response handshake and stall the front of the pipeline until the bus answers.

## Interface
Parameters: none. Widths come from `common`.
- `clk`  input  1  clock, all state on rising edge
- `reset`  input  1  synchronous, active-low; 0 at a rising edge resets
- `dataE`  input  `execute_data_t`  {valid, pc, ctl, alu (address/result), rs2 (store data)}; held stable by upstream while `stallM`=1
- `dreq`  output  `dbus_req_t`  {valid, addr, size, strobe, data}, registered
- `dresp`  input  `dbus_resp_t`  {addr_ok, data_ok, data}
- `dataM`  output  `memory_data_t`  {valid, pc, ctl, alu, rdata, exc_misalign}, registered
- `stallM`  output  1  combinational; upstream must hold `dataE`

## Operation
- Memory op = `dataE.valid && (ctl.MemRead || ctl.MemWrite)`.
- FSM:
  - IDLE, non-memory or invalid input: `stallM`=0. At the edge, `dataM` takes pc, ctl, alu and valid from `dataE`; `rdata`=0.
  - IDLE, memory op: `stallM`=1. At the edge, the `dreq` registers are loaded and the FSM goes to BUSY. `dataM.valid`=0 is written as a bubble.
  - BUSY: `dreq` is held stable. While `data_ok`=0: `stallM`=1, `dataM.valid` is written 0.
  - BUSY with `data_ok`=1: `stallM`=0. At the edge, `dataM` gets the latched pc, ctl and alu plus the formatted `rdata`, `valid`=1. `dreq` is cleared to 0 and the FSM returns to IDLE.
- `addr_ok` is ignored. Completion is `data_ok` only; `data_ok` outside BUSY is ignored.
- Request fields: addr = `alu`, size = `ctl.MemSize`, off = `addr[2:0]`.
- Store: strobe = 8'h01/8'h03/8'h0F/8'hFF for size 1/2/4/8 bytes, shifted left by off. data = `rs2` << (8·off).
- Load: strobe=0. `rdata` = (`dresp.data` >> 8·off), truncated to size, then sign-extended (or zero-extended when `ctl.MemUnsigned`) to 64 bits.
- Store completion: `rdata`=0.

## Timing
- Non-memory op: 1 cycle, `dataM` valid the cycle after it is presented.
- Memory op: `dreq.valid` rises 1 cycle after acceptance. `dataM` is valid 1 cycle after `data_ok`, so the minimum is 2 cycles when `data_ok` comes in the first BUSY cycle.
- Reset values: FSM=IDLE, `dreq`=all zero, `dataM`=all zero.
- `reset` low during BUSY abandons the request: `dreq.valid`=0 the next cycle and no `dataM` is produced.
- Back-to-back memory ops: after a completion edge, the next op is accepted from IDLE the following cycle, so there is at least one IDLE cycle between requests.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - A memory op with `addr` not size-aligned issues no bus request and stays in IDLE.
  - `stallM`=0.
  - At the edge, `dataM` takes valid=1, exc_misalign=1, rdata=0.
- Undefined: no check; `exc_misalign` is tied 0 and a misaligned address is issued as-is.

## Structure
- Package `pipes` holds `memory_data_t` and the `ctl` fields MemRead, MemWrite, MemSize, MemUnsigned.
- Package `common` holds `msize_t` and `dbus_req_t` / `dbus_resp_t`.
- FSM state enum is local.
- Sub-module `mem_format` is combinational:
  - store path: strobe and shifted data;
  - load path: shift, truncate, extend.

## Test plan
- ADD, alu=0x1234, valid: `stallM`=0; next cycle `dataM.valid`=1, alu=0x1234, `dreq.valid`=0.
- SB, addr=0x1003, rs2=0xAB, `data_ok` on first BUSY cycle:
  - `dreq.valid`=1 one cycle after presentation;
  - `dreq` has strobe=0x08, data=0xAB000000;
  - `dataM.valid`=1 two cycles after presentation.
- LH, addr=0x2006, `dresp.data`=0x8001_0000_0000_0000, `data_ok` after 3 BUSY cycles:
  - `stallM`=1 for 4 cycles;
  - `dataM.rdata`=0xFFFF_FFFF_FFFF_8001.
  - Repeat as LHU: `rdata`=0x8001.
- LD addr=0x10 then SD addr=0x18 back-to-back: exactly one request each, `dreq` stable within each BUSY, one IDLE cycle between.
- `reset`=0 during BUSY: next cycle `dreq`=0, `dataM`=0, FSM=IDLE; a later `data_ok` pulse produces no output.
- With `MEM_MISALIGN_CHECK_EN`, LW at addr=0x2: no `dreq.valid`, next cycle `dataM.exc_misalign`=1, valid=1.
